// File: rtl/line_scanout.sv
// Raster timing generator that reads the renderer's ping-pong R/G/B line RAMs.
// Optional build macro SCANOUT_PIXEL_DOUBLE_EN shows each buffer pixel for two clocks.
module line_scanout #(
    parameter int RAM_A_BITS = 8,
    parameter int RAM_D_BITS = 8,
    parameter int H_ACTIVE   = 256,
    parameter int H_FP       = 8,
    parameter int H_SYNC     = 32,
    parameter int H_BP       = 24,
    parameter int V_ACTIVE   = 192,
    parameter int V_FP       = 3,
    parameter int V_SYNC     = 4,
    parameter int V_BP       = 13
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    output logic [RAM_A_BITS-1:0] line_a_rd_a,
    output logic                  line_a_rd_cen,
    input  logic [RAM_D_BITS-1:0] line_a_r_q,
    input  logic [RAM_D_BITS-1:0] line_a_g_q,
    input  logic [RAM_D_BITS-1:0] line_a_b_q,
    output logic [RAM_A_BITS-1:0] line_b_rd_a,
    output logic                  line_b_rd_cen,
    input  logic [RAM_D_BITS-1:0] line_b_r_q,
    input  logic [RAM_D_BITS-1:0] line_b_g_q,
    input  logic [RAM_D_BITS-1:0] line_b_b_q,
    output logic                  line_req,
    output logic [7:0]            line_req_y,
    output logic                  line_req_bank,
    input  logic                  line_done,
    input  logic                  underrun_clr,
    output logic                  underrun_o,
    output logic [RAM_D_BITS-1:0] pix_r,
    output logic [RAM_D_BITS-1:0] pix_g,
    output logic [RAM_D_BITS-1:0] pix_b,
    output logic                  pix_de,
    output logic                  hsync_n,
    output logic                  vsync_n
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);

    localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_ACT    = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] HS_START = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] HS_END   = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] V_ACT    = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] VS_START = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] VS_END   = V_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [H_W-1:0]        h_cnt;
    logic [V_W-1:0]        v_cnt;
    logic [V_W-1:0]        v_next;
    logic                  line_start;
    logic                  h_act;
    logic                  v_act;
    logic                  de;
    logic                  hs;
    logic                  vs;
    logic                  req_bank;
    logic [1:0]            ready;
    logic [1:0]            ready_done;
    logic [1:0]            ready_nxt;
    logic                  pend_vld;
    logic                  pend_bank;
    logic                  line_ok;
    logic                  line_ok_q;
    logic                  fetch;
    logic                  bank_sel;
    logic [RAM_A_BITS-1:0] rd_addr;

    logic                  de_p1;
    logic                  hs_p1;
    logic                  vs_p1;
    logic                  fetch_p1;
    logic                  bank_p1;

    // ---- stage p0: raster counters, requests, read-port drive ----
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            h_cnt <= '0;
            v_cnt <= V_LAST;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= v_next;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    assign v_next     = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    assign line_start = (h_cnt == '0);
    assign h_act      = (h_cnt < H_ACT);
    assign v_act      = (v_cnt < V_ACT);
    assign de         = h_act && v_act;
    assign hs         = (h_cnt >= HS_START) && (h_cnt < HS_END);
    assign vs         = (v_cnt >= VS_START) && (v_cnt < VS_END);

    // Request for the following line goes out at the start of the current one.
    assign line_req      = !wb_rst_i && line_start && (v_next < V_ACT);
    assign req_bank      = v_next[0];
    assign line_req_y    = line_req ? 8'(v_next) : 8'd0;
    assign line_req_bank = line_req && req_bank;

    // A done in the same cycle as a request completes the old bank first.
    always_comb begin
        ready_done = ready;
        if (line_done && pend_vld) begin
            ready_done[pend_bank] = 1'b1;
        end
        ready_nxt = ready_done;
        if (line_req) begin
            ready_nxt[req_bank] = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ready     <= 2'b00;
            pend_vld  <= 1'b0;
            pend_bank <= 1'b0;
        end else begin
            ready <= ready_nxt;
            if (line_req) begin
                pend_vld  <= 1'b1;
                pend_bank <= req_bank;
            end else if (line_done) begin
                pend_vld <= 1'b0;
            end
        end
    end

    // Line readiness is decided once at h_cnt = 0 and held for the whole line.
    assign bank_sel = v_cnt[0];
    assign line_ok  = line_start ? ready_done[bank_sel] : line_ok_q;
    assign fetch    = de && line_ok;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            line_ok_q  <= 1'b0;
            underrun_o <= 1'b0;
        end else begin
            line_ok_q <= line_ok;
            if (line_start && v_act && !ready_done[bank_sel]) begin
                underrun_o <= 1'b1;
            end else if (underrun_clr) begin
                underrun_o <= 1'b0;
            end
        end
    end

`ifdef SCANOUT_PIXEL_DOUBLE_EN
    assign rd_addr = RAM_A_BITS'(h_cnt >> 1);
`else
    assign rd_addr = RAM_A_BITS'(h_cnt);
`endif

    assign line_a_rd_cen = !(fetch && !bank_sel);
    assign line_b_rd_cen = !(fetch && bank_sel);
    assign line_a_rd_a   = (fetch && !bank_sel) ? rd_addr : '0;
    assign line_b_rd_a   = (fetch && bank_sel) ? rd_addr : '0;

    // ---- stage p1: timing delayed while RAM read is in flight ----
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            de_p1    <= 1'b0;
            hs_p1    <= 1'b0;
            vs_p1    <= 1'b0;
            fetch_p1 <= 1'b0;
            bank_p1  <= 1'b0;
        end else begin
            de_p1    <= de;
            hs_p1    <= hs;
            vs_p1    <= vs;
            fetch_p1 <= fetch;
            bank_p1  <= bank_sel;
        end
    end

    // ---- stage p2: registered pixel and sync outputs ----
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            pix_de  <= 1'b0;
            hsync_n <= 1'b1;
            vsync_n <= 1'b1;
            pix_r   <= '0;
            pix_g   <= '0;
            pix_b   <= '0;
        end else begin
            pix_de  <= de_p1;
            hsync_n <= !hs_p1;
            vsync_n <= !vs_p1;
            if (!fetch_p1) begin
                pix_r <= '0;
                pix_g <= '0;
                pix_b <= '0;
            end else if (bank_p1) begin
                pix_r <= line_b_r_q;
                pix_g <= line_b_g_q;
                pix_b <= line_b_b_q;
            end else begin
                pix_r <= line_a_r_q;
                pix_g <= line_a_g_q;
                pix_b <= line_a_b_q;
            end
        end
    end

endmodule

// File: doc/line_scanout.md
Name: line_scanout

Overview:
- Display-side reader of the ping-pong line buffers that the gpu renderer fills.
- Generates raster timing and reads the R/G/B line RAMs through their read ports.
- Emits registered pixel, DE, HSYNC and VSYNC outputs.
- Tells the renderer which line to render into which bank, and flags underruns when a line is not ready in time.

Parameters:
- RAM_A_BITS, 8, line RAM address width.
- RAM_D_BITS, 8, line RAM data width per colour channel.
- H_ACTIVE, 256, visible pixels per line; must be ≤ 2^RAM_A_BITS (≤ 2×2^RAM_A_BITS with doubling).
- H_FP, 8, horizontal front porch in clocks.
- H_SYNC, 32, HSYNC width in clocks.
- H_BP, 24, horizontal back porch in clocks (H_TOTAL = 320).
- V_ACTIVE, 192, visible lines.
- V_FP, 3, vertical front porch in lines.
- V_SYNC, 4, VSYNC width in lines.
- V_BP, 13, vertical back porch in lines (V_TOTAL = 212).

Ports:
- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  synchronous active-high reset
- line_a_rd_a  out  RAM_A_BITS  bank A read address, shared by r/g/b
- line_a_rd_cen  out  1  bank A chip enable, active low
- line_a_r_q, line_a_g_q, line_a_b_q  in  RAM_D_BITS each  bank A read data
- line_b_rd_a, line_b_rd_cen, line_b_r_q, line_b_g_q, line_b_b_q  same roles for bank B
- line_req  out  1  one-cycle pulse: render line line_req_y into bank line_req_bank
- line_req_y  out  8  requested line number
- line_req_bank  out  1  0 = A, 1 = B
- line_done  in  1  one-cycle pulse from renderer: last requested bank is filled
- underrun_clr  in  1  clears underrun_o
- underrun_o  out  1  sticky underrun flag
- pix_r, pix_g, pix_b  out  RAM_D_BITS each  pixel colour
- pix_de  out  1  data enable
- hsync_n, vsync_n  out  1 each  active-low syncs

Behaviour:
- Clock and reset: one clock, wb_clk_i; reset wb_rst_i is synchronous and active-high.
- Counters:
  - h_cnt runs 0..H_TOTAL-1; v_cnt advances when h_cnt wraps and wraps at V_TOTAL-1 → 0.
  - Reset value is h_cnt = 0, v_cnt = V_TOTAL-1, so line 0 is requested first.
- Active region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- Bank selection: line y reads bank y[0] (even lines from A, odd lines from B).
- RAM read side:
  - In the active region, the selected bank is driven with cen = 0 and a = h_cnt; the other bank has cen = 1.
  - Both banks have cen = 1 outside the active region.
  - Read ports never write; write-side pins are owned by the renderer.
  - q is valid one clock after the address.
- Pipeline:
  - Timing signals are delayed by 2 registers; q is captured into the output register.
  - The pixel for counter value (x, y) appears on the outputs exactly 2 clocks after h_cnt = x, aligned with its de/hsync/vsync.
  - hsync_n = 0 when H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC, before the delay.
  - vsync_n = 0 when V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC, before the delay.
  - pix_r/g/b = 0 whenever de = 0.
- Requests:
  - At h_cnt = 0 of line v_cnt, line_req pulses when the next line n = (v_cnt+1) mod V_TOTAL is < V_ACTIVE.
  - line_req_y = n; line_req_bank = n[0].
  - The request clears ready[n[0]] and records that bank as pending.
- Completion:
  - line_done sets ready[pending] and clears pending.
  - line_done with nothing pending is ignored.
  - If line_done and line_req arrive in the same cycle, the done applies to the old pending bank first; then the req clears the new bank and records it pending.
- Underrun:
  - Checked at h_cnt = 0 of active line y: if ready[y[0]] = 0, the whole line outputs pix = 0 while de still toggles normally.
  - cen stays 1 for that line, underrun_o is set, and the next line is handled normally.
  - underrun_clr clears the flag; a new underrun in the same cycle wins, so the flag stays 1.
- Reset values:
  - pix = 0, pix_de = 0, hsync_n = 1, vsync_n = 1, both cen = 1, both addresses = 0.
  - line_req = 0, line_req_y = 0, line_req_bank = 0, underrun_o = 0, ready = 00, pending = none.
- Reset mid-frame: all of the above are restored in the next cycle, the pipeline is flushed (no stale pixels), and an in-flight line_done is dropped.

Optional Feature:
- Macro: SCANOUT_PIXEL_DOUBLE_EN.
- When defined:
  - Each buffer pixel is shown for 2 clocks, with a = h_cnt >> 1.
  - H_ACTIVE is legal up to 2×2^RAM_A_BITS.
  - Pipeline latency is unchanged at 2 clocks.
- When undefined: a = h_cnt, one clock per pixel, no extra logic.

Test Plan:
- Reset: hold wb_rst_i for 3 clocks → hsync_n = vsync_n = 1, pix_de = 0, pix = 0, both cen = 1, underrun_o = 0. First cycle after release → line_req = 1, line_req_y = 0, line_req_bank = 0.
- Normal line: bank-A model returns q = address; done returned 100 clocks after the req → on line 0, pix_r = 0..255 on 256 consecutive clocks, de high throughout, first pixel 2 clocks after h_cnt = 0. Line 1 reads bank B with cen_a = 1.
- Timing: run one full frame → hsync_n low for 32 clocks starting 264 clocks after each line start (+2 latency); vsync_n low for lines 195–198; frame period = 67840 clocks.
- Underrun: withhold line_done for line 5 → line 5 outputs pix = 0 with de high and underrun_o = 1; line 6 outputs correct data; pulse underrun_clr → underrun_o = 0.
- Collision: line_done for line 3 coincident with the req for line 4 → ready[B] set, bank A pending. Line 3 displays with no underrun.
- Reset mid-line at h_cnt = 100, v_cnt = 10 → next cycle all outputs at reset values; the next line_req carries line_req_y = 0.
